// File: rtl/dmem_be.sv
// rtl/dmem_be.sv - two-port data memory with byte enables, registered reads and zero-fill after reset
module dmem_be #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wd0,
    output logic [DATA_W-1:0] rd0,
    output logic              err0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] rd1,
    output logic              err1
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    localparam int UW  = ADDR_W - OFF;
    localparam logic [UW-1:0] DEPTH_U  = UW'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_PEND,
        S_RUN
    } state_t;

    state_t            state;
    logic [IW-1:0]     clr_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IW-1:0]     idx0;
    logic [IW-1:0]     idx1;
    logic              bad0;
    logic              bad1;
    logic              run;
    logic              wr_ok;

    // Port 1 keeps the raw RAM word plus the lanes written on the same edge;
    // the merge happens after the register so addr never reaches rd combinationally.
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] fwd_wd;
    logic [NB-1:0]     fwd_be;

    assign idx0  = addr0[OFF+IW-1:OFF];
    assign idx1  = addr1[OFF+IW-1:OFF];
    assign bad0  = (addr0[OFF-1:0] != '0) | (addr0[ADDR_W-1:OFF] >= DEPTH_U);
    assign bad1  = (addr1[OFF-1:0] != '0) | (addr1[ADDR_W-1:OFF] >= DEPTH_U);
    assign run   = (state == S_RUN);
    assign wr_ok = run & we & ~bad0 & (|be);

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[idx0][8*i +: 8] <= wd0[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_PEND;
            clr_idx <= '0;
            ready   <= 1'b0;
            rd0     <= '0;
            err0    <= 1'b0;
            rd1_q   <= '0;
            err1    <= 1'b0;
            fwd_wd  <= '0;
            fwd_be  <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state <= S_RUN;
                    end
                    ready  <= 1'b0;
                    rd0    <= '0;
                    err0   <= 1'b0;
                    rd1_q  <= '0;
                    err1   <= 1'b0;
                    fwd_be <= '0;
                end
                S_PEND: begin
                    state  <= S_RUN;
                    ready  <= 1'b1;
                    rd0    <= '0;
                    err0   <= 1'b0;
                    rd1_q  <= '0;
                    err1   <= 1'b0;
                    fwd_be <= '0;
                end
                S_RUN: begin
                    ready  <= 1'b1;
                    err0   <= bad0;
                    rd0    <= bad0 ? '0 : mem[idx0];
                    err1   <= bad1;
                    rd1_q  <= bad1 ? '0 : mem[idx1];
                    fwd_wd <= wd0;
                    fwd_be <= (wr_ok && !bad1 && (idx1 == idx0)) ? be : '0;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

    always_comb begin
        rd1 = rd1_q;
        for (int i = 0; i < NB; i++) begin
            if (fwd_be[i]) begin
                rd1[8*i +: 8] = fwd_wd[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_be.md
Name: dmem_be

Overview:
- Parametrised two-port data memory: port 0 read/write with byte enables, port 1 read-only.
- Registered (1-cycle) reads on both ports.
- Hardware zero-fill sequencer after reset; `ready` flag to the core.
- Per-port misaligned / out-of-range error flags.
- Sits between the core's load/store path (port 0) and the display/peripheral reader (port 1).
- Replaces the fixed 32-bit, 1024-word, combinational-read data memory.

Parameters:
- DATA_W, 32: word width in bits; multiple of 8, ≥16.
- DEPTH, 1024: number of words; ≥2.
- ADDR_W, 32: byte-address width.
- CLEAR_ON_RESET, 1: 1 = zero-fill all words after reset; 0 = skip fill.
- Derived:
  - NB = DATA_W/8
  - OFF = $clog2(NB)
  - IW = $clog2(DEPTH)

Ports:
- clk      in   1       rising-edge clock
- rst_n    in   1       reset, asynchronous, active-low
- ready    out  1       memory accepts accesses
- we       in   1       port 0 write enable
- be       in   NB      port 0 byte enables (bit i = byte lane i)
- addr0    in   ADDR_W  port 0 byte address
- wd0      in   DATA_W  port 0 write data
- rd0      out  DATA_W  port 0 read data (registered)
- err0     out  1       port 0 error, aligned with rd0
- addr1    in   ADDR_W  port 1 byte address
- rd1      out  DATA_W  port 1 read data (registered)
- err1     out  1       port 1 error, aligned with rd1

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low: rst_n=0 immediately forces all registered outputs to reset values.
- Reset values: ready=0, rd0=0, rd1=0, err0=0, err1=0, FSM=CLEAR (or RUN-pending if CLEAR_ON_RESET=0), clear index=0. RAM contents are not reset.
- Address decode, per port:
  - Word index = addr[OFF+IW-1:OFF].
  - misaligned = addr[OFF-1:0] != 0.
  - out_of_range = addr[ADDR_W-1:OFF] ≥ DEPTH.
  - err = misaligned | out_of_range.
- FSM states:
  - CLEAR:
    - Each cycle writes 0 to RAM[clr_idx], then clr_idx++.
    - After writing index DEPTH-1, goes to RUN.
    - Fill takes exactly DEPTH cycles.
    - ready rises on the first edge in RUN, i.e. DEPTH+1 edges after rst_n release.
  - CLEAR_ON_RESET=0: go to RUN at the first edge after release; ready=1 from that edge.
  - RUN: normal operation; terminal until reset.
- During CLEAR:
  - we is ignored.
  - rd0, rd1, err0, err1 held at 0.
- Reset mid-CLEAR: fill restarts at index 0; partially filled words are not trusted.
- Port 0 write (RUN, we=1, err0=0): for each lane i with be[i]=1, RAM[idx0][8i+7:8i] <= wd0[8i+7:8i]; other lanes unchanged.
- Errored write (err0=1): no RAM change; err0 registered high.
- we=1 with be=0: no RAM change, no error.
- Port 0 read: every RUN edge, rd0 <= RAM[idx0] (read-before-write: same-cycle write is not visible in rd0); rd0 <= 0 if err0.
- Port 1 read: every RUN edge, rd1 <= RAM[idx1]; rd1 <= 0 if err1.
- Port 1 forwarding: if the same edge performs a valid port 0 write and idx1==idx0, rd1 <= the merged word (enabled lanes from wd0, others from RAM).
- err0/err1: registered each edge; high for one cycle per erroring access; no sticky state.
- Latency: address at edge N → data/err valid after edge N, until the next edge.
- rd0/rd1 update every RUN cycle; no read enable.
- Implementation: inferable as block RAM plus forwarding mux; no combinational path from addr to rd.

Test Plan (DEPTH=16, DATA_W=32 unless noted):
- Reset fill:
  - Preload RAM with 0xFFFFFFFF via backdoor, pulse rst_n low, release → ready=0 for 16 edges, 1 on edge 17.
  - All 16 words read 0x00000000 on both ports.
  - Writes issued during CLEAR leave no trace.
- Byte enables: write 0xAABBCCDD be=1111 at addr 0x8, then 0x11223344 be=0101 → rd0 at 0x8 = 0xAA22CC44; be=0000 → unchanged.
- Read-before-write vs forwarding:
  - Word 0x4 holds 0x1; same cycle: we=1, addr0=addr1=0x4, wd0=0x5, be=1111.
  - Next cycle: rd0=0x1, rd1=0x5; following cycle both read 0x5.
- Errors:
  - addr0=0x6 with we=1 → err0=1 one cycle, rd0=0, RAM word 1 unchanged.
  - addr1=0x40 (index 16) → err1=1, rd1=0.
  - addr1=0x3C → err1=0.
- Async reset mid-fill: assert rst_n low at fill cycle 7 without clock → ready/rd0/rd1 go 0 immediately; after release the fill takes a full 16 cycles.
- Generics: DATA_W=64, DEPTH=8, CLEAR_ON_RESET=0 → ready=1 one edge after release.
  - be=0x0F write of 0x0123456789ABCDEF at 0x10 sets only the low 32 bits.
  - addr 0x14 flags misaligned.
